// File: rtl/node_seq_ctrl.sv
// Sequences one shared combinational node across NUM_NODES logical nodes per accepted (x, y) pair.
// Latency: first result valid 2 cycles after the input handshake, then one result per 2 cycles.
// Backpressure: out_* hold while out_valid && !out_ready; in_ready is high only in IDLE.
module node_seq_ctrl #(
    parameter int WIDTH     = 10,
    parameter int NUM_NODES = 4,
    parameter int IDX_W     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [WIDTH-1:0] cfg_multa,
    input  logic [WIDTH-1:0] cfg_multb,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic [WIDTH-1:0] node_a,
    output logic [WIDTH-1:0] node_b,
    output logic [WIDTH-1:0] node_multa,
    output logic [WIDTH-1:0] node_multb,
    input  logic [WIDTH-1:0] node_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        OUT   = 2'd2
    } state_t;

    // One extra bit so NUM_NODES == 2**IDX_W is still representable.
    localparam logic [IDX_W:0]   LP_NUM  = NUM_NODES[IDX_W:0];
    localparam logic [IDX_W-1:0] LP_LAST = IDX_W'(NUM_NODES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_coef_a [NUM_NODES];
    logic [WIDTH-1:0] r_coef_b [NUM_NODES];
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [IDX_W-1:0] r_out_idx;
    logic             r_out_last;

    logic w_accept;
    logic w_out_hs;
    logic w_cfg_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_out_hs    = 1'b0;
        w_cfg_wr    = 1'b0;
        case (r_state)
            IDLE: begin
                w_cfg_wr = cfg_we && ({1'b0, cfg_idx} < LP_NUM);
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_state_nxt = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    w_out_hs    = 1'b1;
                    w_state_nxt = r_out_last ? IDLE : ISSUE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            for (int i = 0; i < NUM_NODES; i++) begin
                r_coef_a[i] <= '0;
                r_coef_b[i] <= '0;
            end
        end else begin
            // A write in the accepting cycle is visible to the pass: ISSUE reads it next cycle.
            if (w_cfg_wr) begin
                r_coef_a[cfg_idx] <= cfg_multa;
                r_coef_b[cfg_idx] <= cfg_multb;
            end
            if (w_accept) begin
                r_x   <= in_x;
                r_y   <= in_y;
                r_idx <= '0;
            end
            if (r_state == ISSUE) begin
                r_out_data  <= node_result;
                r_out_idx   <= r_idx;
                r_out_last  <= (r_idx == LP_LAST);
                r_out_valid <= 1'b1;
            end
            if (w_out_hs) begin
                r_out_valid <= 1'b0;
                if (!r_out_last) begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign node_a     = r_x;
    assign node_b     = r_y;
    assign node_multa = r_coef_a[r_idx];
    assign node_multb = r_coef_b[r_idx];
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_idx    = r_out_idx;
    assign out_last   = r_out_last;

endmodule

// File: tb/tb_node_seq_ctrl.sv
// Bench for node_seq_ctrl: a behavioural shared node, directed stimulus and a queue-based
// scoreboard whose monitor pops one expected result per output handshake.
module tb_node_seq_ctrl;

    localparam int W = 10;
    localparam int N = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [W-1:0]  cfg_multa;
    logic [W-1:0]  cfg_multb;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_x;
    logic [W-1:0]  in_y;
    logic [W-1:0]  node_a;
    logic [W-1:0]  node_b;
    logic [W-1:0]  node_multa;
    logic [W-1:0]  node_multb;
    logic [W-1:0]  node_result;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          busy;

    typedef struct {
        logic [W-1:0]  d;
        logic [IW-1:0] i;
        logic          l;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    // Shared node model: WIDTH-bit unsigned, wraps modulo 2**WIDTH.
    assign node_result = node_a * node_multa + node_b * node_multb;

    node_seq_ctrl #(.WIDTH(W), .NUM_NODES(N), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_multa(cfg_multa), .cfg_multb(cfg_multb),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .node_a(node_a), .node_b(node_b), .node_multa(node_multa), .node_multb(node_multb),
        .node_result(node_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push_pass(input logic [W-1:0] d0, d1, d2, d3);
        logic [W-1:0] d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        for (int k = 0; k < N; k++) begin
            exp_t e;
            e.d = d[k];
            e.i = IW'(k);
            e.l = (k == N - 1);
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_data", 32'(out_data), 32'(e.d));
                chk("out_idx", 32'(out_idx), 32'(e.i));
                chk("out_last", 32'(out_last), 32'(e.l));
            end
        end
    end

    task automatic cfg_write(input logic [IW-1:0] idx, input logic [W-1:0] a, b);
        cfg_we = 1'b1; cfg_idx = idx; cfg_multa = a; cfg_multb = b;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] x, y, input bit chk_lat);
        int  n;
        bit  acc;
        n = 0; acc = 1'b0;
        in_x = x; in_y = y; in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk("accept", 32'(acc), 32'd1);
        if (chk_lat) begin
            chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
            chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_queue_left", 32'(exp_q.size()), 32'd0);
        chk("drain_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_multa = '0; cfg_multb = '0;
        in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b1;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_node_a", 32'(node_a), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: basic pass with latency check
        cfg_write(2'd0, 10'd3, 10'd5);
        push_pass(10'd130, 10'd0, 10'd0, 10'd0);
        send(10'd10, 10'd20, 1'b1);
        chk("busy_in_pass", 32'(busy), 32'd1);
        drain();

        // 2: wrap modulo 1024 passes through untouched
        cfg_write(2'd0, 10'd11, 10'd0);
        push_pass(10'd76, 10'd0, 10'd0, 10'd0);
        send(10'd100, 10'd7, 1'b0);
        drain();

        // 3: backpressure holds outputs stable for 5 cycles
        cfg_write(2'd1, 10'd2, 10'd3);
        out_ready = 1'b0;
        push_pass(10'd11, 10'd8, 10'd0, 10'd0);
        send(10'd1, 10'd2, 1'b0);
        wait_valid();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'd11);
            chk("stall_idx", 32'(out_idx), 32'd0);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        drain();

        // 4: config write while busy is dropped; same write in IDLE applies
        out_ready = 1'b0;
        push_pass(10'd55, 10'd13, 10'd0, 10'd0);
        send(10'd5, 10'd1, 1'b0);
        wait_valid();
        cfg_write(2'd1, 10'd9, 10'd9);
        out_ready = 1'b1;
        drain();
        cfg_write(2'd1, 10'd9, 10'd9);
        push_pass(10'd55, 10'd54, 10'd0, 10'd0);
        send(10'd5, 10'd1, 1'b0);
        drain();

        // 5: config write and input accept in the same IDLE cycle
        cfg_we = 1'b1; cfg_idx = 2'd2; cfg_multa = 10'd1; cfg_multb = 10'd1;
        push_pass(10'd44, 10'd90, 10'd10, 10'd0);
        send(10'd4, 10'd6, 1'b0);
        cfg_we = 1'b0;
        drain();

        // 6: asynchronous reset mid-pass at idx2
        push_pass(10'd22, 10'd45, 10'd5, 10'd0);
        send(10'd2, 10'd3, 1'b0);
        n = 0;
        while (!(out_valid && out_idx == 2'd2) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_idx2", 32'(out_idx), 32'd2);
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_out_idx", 32'(out_idx), 32'd0);
        chk("arst_out_last", 32'(out_last), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_node_multa", 32'(node_multa), 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("post_rst_no_valid", 32'(out_valid), 32'd0);
            chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        end
        // Coefficients were cleared: every node now yields zero
        push_pass(10'd0, 10'd0, 10'd0, 10'd0);
        send(10'd7, 10'd8, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
